// File: rtl/uart_rx_framed.sv
// UART receiver with configurable character format (5-8 data bits, none/odd/even parity, 1-2 stop bits).
// Flags parity, framing, break and overrun errors, and holds each character in a one-entry valid/ready register.
module uart_rx_framed #(
    parameter int CYCLES_PER_BIT = 217,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_serial_rx,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_break,
    output logic       o_busy
);
    localparam int HALF = CYCLES_PER_BIT / 2;
    localparam int CW   = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] BIT_END   = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] MID_END   = CW'(HALF - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, PAR, STOP} state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [1:0]    settle;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    data;
    logic          par_bit, par_err, stop_err;
    logic          tick, done, brk_det, frame_bad;
    logic          hs, accept;

    // settle holds WAIT_HIGH off until the synchronizer carries the real pin,
    // so a line held low across reset release is never mistaken for a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            settle <= 2'b00;
        end else begin
            rx_m   <= i_serial_rx;
            rx_s   <= rx_m;
            settle <= {settle[0], 1'b1};
        end
    end

    always_comb begin
        tick      = (state == START) ? (cnt == MID_END) : (cnt == BIT_END);
        state_n   = state;
        done      = 1'b0;
        brk_det   = 1'b0;
        frame_bad = stop_err | ~rx_s;
        case (state)
            WAIT_HIGH: if (settle[1] && rx_s) state_n = IDLE;
            IDLE:      if (!rx_s) state_n = START;
            START:     if (tick) state_n = rx_s ? IDLE : DATA;
            DATA:      if (tick && idx == LAST_DATA) state_n = (PARITY != 0) ? PAR : STOP;
            PAR:       if (tick) state_n = STOP;
            STOP: begin
                if (tick && idx == LAST_STOP) begin
                    // par_bit stays 0 when there is no parity bit
                    brk_det = (data == 8'h00) && !par_bit && !rx_s;
                    done    = !brk_det;
                    state_n = frame_bad ? WAIT_HIGH : IDLE;
                end
            end
            default:   state_n = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= WAIT_HIGH;
            cnt      <= '0;
            idx      <= '0;
            data     <= '0;
            par_bit  <= 1'b0;
            par_err  <= 1'b0;
            stop_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state == IDLE || state == WAIT_HIGH || tick) ? '0 : cnt + CW'(1);
            idx   <= (state_n != state) ? 3'd0 : (tick ? idx + 3'd1 : idx);
            if (state == IDLE) begin
                data     <= '0;
                par_bit  <= 1'b0;
                par_err  <= 1'b0;
                stop_err <= 1'b0;
            end
            if (tick) begin
                case (state)
                    DATA: data[idx] <= rx_s;
                    PAR: begin
                        par_bit <= rx_s;
                        par_err <= (PARITY == 1) ? ~(^data ^ rx_s) : (^data ^ rx_s);
                    end
                    STOP: if (!rx_s) stop_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // A character may load in the same cycle the held one is accepted.
    assign hs     = o_rx_valid & i_rx_ready;
    assign accept = done & (~o_rx_valid | i_rx_ready);
    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_byte    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            o_break <= brk_det;
            if (accept) begin
                o_rx_byte    <= data;
                o_parity_err <= par_err;
                o_frame_err  <= frame_bad;
                o_rx_valid   <= 1'b1;
            end else if (hs) begin
                o_rx_valid   <= 1'b0;
                o_parity_err <= 1'b0;
                o_frame_err  <= 1'b0;
            end
            if (done && !accept) o_overrun <= 1'b1;
            else if (hs)         o_overrun <= 1'b0;
        end
    end
endmodule
